// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Holds the FSM state enum and the default operand width.
package div_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_sub_stage.sv
// Trial subtract of one restoring-division step.
// Ports: rem_i (shifted partial remainder, WIDTH+1 bits), dvs_i (divisor),
//        diff_o (rem_i - dvs_i, valid when nonneg_o), nonneg_o (rem_i >= dvs_i).
module div_sub_stage
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             nonneg_o
);

    assign nonneg_o = (rem_i >= {1'b0, dvs_i});

    // A kept difference is always below the divisor, so the low
    // WIDTH bits carry the whole result.
    assign diff_o = rem_i[WIDTH-1:0] - dvs_i;

endmodule

// File: rtl/div_iter_16bit.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Ports: clk, rst (sync, active-high), start, dividend, divisor ->
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero.
// Macro DIV_ZERO_FAST_EN: zero divisor finishes one cycle after start.
module div_iter_16bit
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rmd_q;

    logic [WIDTH:0]   shift_d;
    logic [WIDTH-1:0] diff;
    logic             nonneg;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dvd_d;

    // dvd_q shifts out dividend bits at the top while quotient
    // bits enter at the bottom; after WIDTH steps it is the quotient.
    assign shift_d = {rem_q, dvd_q[WIDTH-1]};

    div_sub_stage #(
        .WIDTH(WIDTH)
    ) u_sub (
        .rem_i   (shift_d),
        .dvs_i   (dvs_q),
        .diff_o  (diff),
        .nonneg_o(nonneg)
    );

    assign rem_d = nonneg ? diff : shift_d[WIDTH-1:0];
    assign dvd_d = {dvd_q[WIDTH-2:0], nonneg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        rem_q <= '0;
                        cnt_q <= CNT_TOP;
`ifdef DIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            quo_q   <= '1;
                            rmd_q   <= dividend;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= RUN;
                        busy_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quo_q   <= dvd_d;
                        rmd_q   <= rem_d;
                        dbz_q   <= (dvs_q == '0);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_iter_16bit.sv
// Directed scoreboard bench for div_iter_16bit.
// Expected results are queued at start and checked on each done pulse.
module tb_div_iter_16bit;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          cyc;
        int          bsy;
    } exp_t;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT  = 1;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = 17;
    localparam int ZBUSY = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   edges = 0;
    int   bcnt = 0;
    exp_t sb[$];
    exp_t e;

    div_iter_16bit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle k is the interval closed by posedge k; at a negedge
    // the current cycle index is edges+1.
    always @(negedge clk) begin
        if (rst) begin
            bcnt = 0;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", {16'b0, quotient}, {16'b0, e.q});
                chk("remainder", {16'b0, remainder}, {16'b0, e.r});
                chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
                chk("done_cycle", edges + 1, e.cyc);
                chk("busy_cycles", bcnt, e.bsy);
            end
            bcnt = 0;
        end else if (busy) begin
            bcnt++;
        end
    end

    // Drive start in the current cycle and queue its expectation.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic [15:0] r,
                         input logic z, input int lat, input int bz);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back('{q: q, r: r, z: z, cyc: edges + 1 + lat, bsy: bz});
    endtask

    task automatic do_start(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] q, input logic [15:0] r,
                            input logic z, input int lat, input int bz);
        @(negedge clk);
        issue(a, b, q, r, z, lat, bz);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sb.size(), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_q"}, {16'b0, quotient}, 32'd0);
        chk({tag, "_r"}, {16'b0, remainder}, 32'd0);
        chk({tag, "_dbz"}, {31'b0, div_by_zero}, 32'd0);
    endtask

    initial begin
        int t0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        do_start(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16);
        drain("t_100_7");

        do_start(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17, 16);
        drain("t_ffff_1");

        do_start(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17, 16);
        drain("t_3_10");

        do_start(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, ZLAT, ZBUSY);
        drain("t_5_0");
        repeat (3) @(negedge clk);
        chk("hold_q", {16'b0, quotient}, 32'h0000FFFF);
        chk("hold_r", {16'b0, remainder}, 32'd5);
        chk("hold_dbz", {31'b0, div_by_zero}, 32'd1);
        chk("hold_done", {31'b0, done}, 32'd0);
        chk("hold_busy", {31'b0, busy}, 32'd0);

        // A second start while running must be ignored.
        do_start(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16);
        repeat (2) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd3;
        @(negedge clk);
        start = 1'b0;
        drain("t_ignore");

        // Abort after eight iterations; no done may follow.
        do_start(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        chk_zero("abort");
        rst = 1'b0;
        repeat (25) @(negedge clk);
        do_start(16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 17, 16);
        drain("t_9_2");

        // Back-to-back: new start issued in the DONE cycle.
        @(negedge clk);
        t0 = edges + 1;
        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16);
        @(negedge clk);
        start = 1'b0;
        while (edges + 1 < t0 + 17) @(negedge clk);
        chk("b2b_done_now", {31'b0, done}, 32'd1);
        issue(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 17, 16);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        drain("t_b2b");

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
